// File: rtl/regfile_pkg.sv
// regfile_pkg: function codes, context commands and FSM states shared by the register file.
package regfile_pkg;

    typedef enum logic [2:0] {
        FS_DEC,
        FS_INC,
        FS_LOAD,
        FS_CLR,
        FS_CLR_LO,
        FS_WR_LO,
        FS_WR_HI,
        FS_SEXT_LO
    } fun_sel_e;

    localparam logic [1:0] CTX_NONE    = 2'b00;
    localparam logic [1:0] CTX_SAVE    = 2'b01;
    localparam logic [1:0] CTX_RESTORE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE
    } state_e;

endpackage

// File: rtl/param_register.sv
// param_register: one register with its function unit; d is the next value.
// With REGFILE_BYPASS_EN defined, d is also exported for write-through reads.
module param_register
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  fun_sel_e         fun_sel,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
`ifdef REGFILE_BYPASS_EN
    ,
    output logic [WIDTH-1:0] d
`endif
);

    localparam int HALF = WIDTH / 2;

`ifndef REGFILE_BYPASS_EN
    logic [WIDTH-1:0] d;
`endif
    logic [WIDTH-1:0] f;

    always_comb begin
        case (fun_sel)
            FS_DEC:    f = q - WIDTH'(1);
            FS_INC:    f = q + WIDTH'(1);
            FS_LOAD:   f = data;
            FS_CLR:    f = '0;
            FS_CLR_LO: f = {{HALF{1'b0}}, data[HALF-1:0]};
            FS_WR_LO:  f = {q[WIDTH-1:HALF], data[HALF-1:0]};
            FS_WR_HI:  f = {data[HALF-1:0], q[HALF-1:0]};
            default:   f = {{HALF{data[HALF-1]}}, data[HALF-1:0]};
        endcase
        d = en ? f : q;
    end

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/param_register_file.sv
// param_register_file: R/S register file with two async read ports and a shadow-bank save/restore FSM.
// Define REGFILE_BYPASS_EN to make reads of a register being written return its next value.
module param_register_file
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N_GPR = 4,
    parameter  int N_SCR = 4,
    localparam int SELW  = $clog2(N_GPR + N_SCR)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [N_GPR-1:0] RegSel,
    input  logic [N_SCR-1:0] ScrSel,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    input  logic [1:0]       Ctx,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic             Busy
);

    localparam int N  = N_GPR + N_SCR;
    localparam int KW = N_GPR > 1 ? $clog2(N_GPR) : 1;

    state_e           state, next_state;
    logic [KW-1:0]    k;
    logic             last;
    logic [WIDTH-1:0] shadow [N_GPR];
    logic [WIDTH-1:0] r      [N_GPR];
    logic [WIDTH-1:0] q      [N];
    logic [WIDTH-1:0] rd     [N];

    assign last = int'(k) == N_GPR - 1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= next_state;
            k     <= (state == ST_IDLE || last) ? '0 : k + KW'(1);
        end
    end

    always_comb begin
        next_state = state == ST_IDLE ? (Ctx == CTX_SAVE    ? ST_SAVE :
                                         Ctx == CTX_RESTORE ? ST_RESTORE : ST_IDLE) :
                     last ? ST_IDLE : state;
    end

    always_comb begin
        Busy = state != ST_IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int n = 0; n < N_GPR; n++) shadow[n] <= '0;
        end else if (state == ST_SAVE) begin
            shadow[k] <= r[k];
        end
    end

    // R-regs take the shadow value while being restored; RegSel is locked out while busy.
    for (genvar g = 0; g < N; g++) begin : g_reg
        logic             en;
        fun_sel_e         fun;
        logic [WIDTH-1:0] data;
        if (g < N_GPR) begin : g_r
            logic hit;
            assign hit  = state == ST_RESTORE && int'(k) == g;
            assign en   = hit || (!Busy && !RegSel[N_GPR-1-g]);
            assign fun  = hit ? FS_LOAD : fun_sel_e'(FunSel);
            assign data = hit ? shadow[g] : I;
            assign r[g] = q[g];
        end else begin : g_s
            assign en   = !ScrSel[N-1-g];
            assign fun  = fun_sel_e'(FunSel);
            assign data = I;
        end
        param_register #(.WIDTH(WIDTH)) u_reg (
            .clk     (Clock),
            .rst     (Reset),
            .en      (en),
            .fun_sel (fun),
            .data    (data),
`ifdef REGFILE_BYPASS_EN
            .d       (rd[g]),
`endif
            .q       (q[g])
        );
`ifndef REGFILE_BYPASS_EN
        assign rd[g] = q[g];
`endif
    end

    assign OutA = int'(OutASel) < N ? rd[OutASel] : '0;
    assign OutB = int'(OutBSel) < N ? rd[OutBSel] : '0;

endmodule
